control_unit: RTL

- Multi-cycle control sequencer for the Phase 3 32-bit RISC datapath.
- Steps through fetch/decode/execute states.
- Drives the select-and-encode block's register-select and in/out strobes.
- Also drives the PC, MAR, MDR, IR, Y and Z register enables, the memory strobes and the ALU operation code.
- Sits beside the datapath and consumes only IR_Out, CON_FF and the external Stop request.

---
 rtl/cpu_ctrl_pkg.sv | 95 +++++++++
 rtl/ctrl_decode.sv | 114 +++++++++++
 rtl/control_unit.sv | 134 +++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the multi-cycle control sequencer:
// opcode encodings, sequencer states, ALU operation codes and the
// control strobe bundle produced by the decoder.
package cpu_ctrl_pkg;

   localparam int ALU_OP_WIDTH = 4;

   // Sequencer states; T0..T7 are instruction steps, HALT is terminal
   typedef enum logic [3:0] {
      ST_T0   = 4'd0,
      ST_T1   = 4'd1,
      ST_T2   = 4'd2,
      ST_T3   = 4'd3,
      ST_T4   = 4'd4,
      ST_T5   = 4'd5,
      ST_T6   = 4'd6,
      ST_T7   = 4'd7,
      ST_HALT = 4'd8
   } state_t;

   typedef enum logic [ALU_OP_WIDTH-1:0] {
      ALU_ADD = 4'd0,
      ALU_SUB = 4'd1,
      ALU_AND = 4'd2,
      ALU_OR  = 4'd3
   } alu_op_t;

   // Opcode field IR[31:27]
   localparam logic [4:0] OP_LD   = 5'b00000;
   localparam logic [4:0] OP_LDI  = 5'b00001;
   localparam logic [4:0] OP_ST   = 5'b00010;
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_ADDI = 5'b01100;
   localparam logic [4:0] OP_ANDI = 5'b01101;
   localparam logic [4:0] OP_ORI  = 5'b01110;
   localparam logic [4:0] OP_BR   = 5'b10010;
   localparam logic [4:0] OP_JR   = 5'b10011;
   localparam logic [4:0] OP_NOP  = 5'b11000;
   localparam logic [4:0] OP_HALT = 5'b11001;

   // One bit per datapath strobe plus the ALU operation
   typedef struct packed {
      logic    pc_out;
      logic    pc_in;
      logic    inc_pc;
      logic    mar_in;
      logic    mdr_in;
      logic    mdr_out;
      logic    ir_in;
      logic    read;
      logic    write;
      logic    y_in;
      logic    z_in;
      logic    zlo_out;
      logic    c_out;
      logic    g_ra;
      logic    g_rb;
      logic    g_rc;
      logic    r_in;
      logic    r_out;
      logic    ba_out;
      logic    con_in;
      alu_op_t alu_op;
   } ctrl_t;

   function automatic logic is_rtype(input logic [4:0] op);
      return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
   endfunction

   function automatic logic is_imm(input logic [4:0] op);
      return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI);
   endfunction

   // ALU operation used at T4 by the arithmetic/logic opcodes
   function automatic alu_op_t alu_of(input logic [4:0] op);
      case (op)
         OP_SUB:          return ALU_SUB;
         OP_AND, OP_ANDI: return ALU_AND;
         OP_OR,  OP_ORI:  return ALU_OR;
         default:         return ALU_ADD;
      endcase
   endfunction

   // Last step of each instruction; leaving it returns to T0 (or HALT on Stop)
   function automatic state_t last_state(input logic [4:0] op);
      if (is_rtype(op) || is_imm(op) || op == OP_LDI) return ST_T5;
      if (op == OP_LD || op == OP_ST)                  return ST_T7;
      if (op == OP_BR)                                 return ST_T6;
      return ST_T3;
   endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Purely combinational Moore decode: (state, opcode, CON_FF) -> strobes.
module ctrl_decode
   import cpu_ctrl_pkg::*;
(
   input  state_t     state,
   input  logic [4:0] opcode,
   input  logic       con_ff,
   output ctrl_t      ctrl
);

   logic rtype;
   logic imm;
   logic addr_calc;   // ld/ldi/st share the base+offset address steps

   assign rtype     = is_rtype(opcode);
   assign imm       = is_imm(opcode);
   assign addr_calc = (opcode == OP_LD) || (opcode == OP_LDI) || (opcode == OP_ST);

   // Strobe table per state, specialised by opcode from T3 on
   always_comb begin
      ctrl        = '0;
      ctrl.alu_op = ALU_ADD;
      case (state)
         ST_T0: begin
            ctrl.pc_out = 1'b1;
            ctrl.mar_in = 1'b1;
            ctrl.inc_pc = 1'b1;
         end
         ST_T1: begin
            ctrl.read   = 1'b1;
            ctrl.mdr_in = 1'b1;
         end
         ST_T2: begin
            ctrl.mdr_out = 1'b1;
            ctrl.ir_in   = 1'b1;
         end
         ST_T3: begin
            if (rtype || imm) begin
               ctrl.g_rb  = 1'b1;
               ctrl.r_out = 1'b1;
               ctrl.y_in  = 1'b1;
            end else if (addr_calc) begin
               ctrl.g_rb   = 1'b1;
               ctrl.ba_out = 1'b1;
               ctrl.y_in   = 1'b1;
            end else if (opcode == OP_BR) begin
               ctrl.g_ra   = 1'b1;
               ctrl.r_out  = 1'b1;
               ctrl.con_in = 1'b1;
            end else if (opcode == OP_JR) begin
               ctrl.g_ra  = 1'b1;
               ctrl.r_out = 1'b1;
               ctrl.pc_in = 1'b1;
            end
         end
         ST_T4: begin
            if (rtype) begin
               ctrl.g_rc   = 1'b1;
               ctrl.r_out  = 1'b1;
               ctrl.z_in   = 1'b1;
               ctrl.alu_op = alu_of(opcode);
            end else if (imm) begin
               ctrl.c_out  = 1'b1;
               ctrl.z_in   = 1'b1;
               ctrl.alu_op = alu_of(opcode);
            end else if (addr_calc) begin
               ctrl.c_out = 1'b1;
               ctrl.z_in  = 1'b1;
            end else if (opcode == OP_BR) begin
               ctrl.pc_out = 1'b1;
               ctrl.y_in   = 1'b1;
            end
         end
         ST_T5: begin
            if (rtype || imm || opcode == OP_LDI) begin
               ctrl.zlo_out = 1'b1;
               ctrl.g_ra    = 1'b1;
               ctrl.r_in    = 1'b1;
            end else if (opcode == OP_LD || opcode == OP_ST) begin
               ctrl.zlo_out = 1'b1;
               ctrl.mar_in  = 1'b1;
            end else if (opcode == OP_BR) begin
               ctrl.c_out = 1'b1;
               ctrl.z_in  = 1'b1;
            end
         end
         ST_T6: begin
            if (opcode == OP_LD) begin
               ctrl.read   = 1'b1;
               ctrl.mdr_in = 1'b1;
            end else if (opcode == OP_ST) begin
               // MDR loads from the bus here, so Read stays low
               ctrl.g_ra   = 1'b1;
               ctrl.r_out  = 1'b1;
               ctrl.mdr_in = 1'b1;
            end else if (opcode == OP_BR) begin
               ctrl.zlo_out = 1'b1;
               ctrl.pc_in   = con_ff;
            end
         end
         ST_T7: begin
            if (opcode == OP_LD) begin
               ctrl.mdr_out = 1'b1;
               ctrl.g_ra    = 1'b1;
               ctrl.r_in    = 1'b1;
            end else if (opcode == OP_ST) begin
               ctrl.write = 1'b1;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle control sequencer: state register, next-state/Stop logic,
// and gating of the decoded strobes so nothing is driven in reset or HALT.
module control_unit
   import cpu_ctrl_pkg::*;
#(
   parameter int ALU_OP_W = ALU_OP_WIDTH
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic [31:0]         IR_Out,
   input  logic                CON_FF,
   input  logic                Stop,
   output logic                PC_Out,
   output logic                PC_In,
   output logic                IncPC,
   output logic                MAR_In,
   output logic                MDR_In,
   output logic                MDR_Out,
   output logic                IR_In,
   output logic                Read,
   output logic                Write,
   output logic                Y_In,
   output logic                Z_In,
   output logic                Zlo_Out,
   output logic                C_Out,
   output logic                G_RA,
   output logic                G_RB,
   output logic                G_RC,
   output logic                R_In,
   output logic                R_Out,
   output logic                BA_Out,
   output logic                CON_In,
   output logic [ALU_OP_W-1:0] ALU_Op,
   output logic                Run
);

   state_t     state_reg, state_next;
   logic       active_reg;          // low until the first edge after reset release
   logic       stop_pending_reg, stop_pending_next;
   logic [4:0] opcode;
   logic       run;
   ctrl_t      dec_ctrl;
   ctrl_t      ctrl;
   logic       unused_ir;

   assign opcode    = IR_Out[31:27];
   assign unused_ir = ^IR_Out[26:0];
   assign run       = active_reg && (state_reg != ST_HALT);

   ctrl_decode u_decode (
      .state  (state_reg),
      .opcode (opcode),
      .con_ff (CON_FF),
      .ctrl   (dec_ctrl)
   );

   // State register; reset forces T0 and drops every strobe at once
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_reg        <= ST_T0;
         active_reg       <= 1'b0;
         stop_pending_reg <= 1'b0;
      end else begin
         state_reg        <= state_next;
         active_reg       <= 1'b1;
         stop_pending_reg <= stop_pending_next;
      end
   end

   // Next state; a Stop seen at any time during an instruction is held
   // and only acted on when leaving that instruction's last step
   always_comb begin
      state_next        = state_reg;
      stop_pending_next = stop_pending_reg;
      if (!active_reg) begin
         state_next = ST_T0;
      end else begin
         stop_pending_next = stop_pending_reg | Stop;
         case (state_reg)
            ST_HALT: state_next = ST_HALT;
            default: begin
               if (state_reg == ST_T3 && opcode == OP_HALT)
                  state_next = ST_HALT;
               else if (state_reg == last_state(opcode))
                  state_next = (Stop || stop_pending_reg) ? ST_HALT : ST_T0;
               else
                  state_next = state_t'(state_reg + 4'd1);
            end
         endcase
      end
   end

   // Output decode, forced idle outside of normal execution
   always_comb begin
      ctrl        = '0;
      ctrl.alu_op = ALU_ADD;
      if (run)
         ctrl = dec_ctrl;
   end

   assign PC_Out  = ctrl.pc_out;
   assign PC_In   = ctrl.pc_in;
   assign IncPC   = ctrl.inc_pc;
   assign MAR_In  = ctrl.mar_in;
   assign MDR_In  = ctrl.mdr_in;
   assign MDR_Out = ctrl.mdr_out;
   assign IR_In   = ctrl.ir_in;
   assign Read    = ctrl.read;
   assign Write   = ctrl.write;
   assign Y_In    = ctrl.y_in;
   assign Z_In    = ctrl.z_in;
   assign Zlo_Out = ctrl.zlo_out;
   assign C_Out   = ctrl.c_out;
   assign G_RA    = ctrl.g_ra;
   assign G_RB    = ctrl.g_rb;
   assign G_RC    = ctrl.g_rc;
   assign R_In    = ctrl.r_in;
   assign R_Out   = ctrl.r_out;
   assign BA_Out  = ctrl.ba_out;
   assign CON_In  = ctrl.con_in;
   assign ALU_Op  = ALU_OP_W'(ctrl.alu_op);
   assign Run     = run;

   // Strobe exclusivity invariants
   a_one_sel : assert property (@(posedge clock) disable iff (!reset_n)
      $onehot0({G_RA, G_RB, G_RC}));
   a_rin_excl : assert property (@(posedge clock) disable iff (!reset_n)
      !(R_In && (R_Out || BA_Out)));
   a_rw_excl : assert property (@(posedge clock) disable iff (!reset_n)
      !(Read && Write));
   a_one_drv : assert property (@(posedge clock) disable iff (!reset_n)
      $onehot0({PC_Out, MDR_Out, Zlo_Out, C_Out, R_Out, BA_Out}));

endmodule
